// File: rtl/kernel_launcher_pkg.sv
// kernel_launcher_pkg: shared types and constants for the kernel launcher.
//   state_t          launcher sequencing states (2-bit encoding)
//   DEFAULT_TIMEOUT  default watchdog limit, in WAIT cycles
package kernel_launcher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/launcher_watchdog.sv
// launcher_watchdog: CNT_W-bit cycle counter with synchronous clear and
// count enable. It raises expire while the count equals TIMEOUT-1. The
// same count doubles as the WAIT-cycle latency measure.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     force the count to zero on the next edge (wins over enable)
//   enable    increment the count on the next edge
//   count     current count value
//   expire    count == TIMEOUT-1
module launcher_watchdog
    import kernel_launcher_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count  = count_reg;
    assign expire = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/kernel_launcher.sv
// kernel_launcher: caller-side sequencer for one r_enable/w_enable compute
// kernel. The launcher accepts an operand vector, pulses k_r_enable for one
// cycle with the operands held on k_init, and waits for k_w_enable. It then
// returns the kernel result, or 0 with rsp_timeout set when the watchdog
// expires. All outputs are registered.
// Optional feature: define KERNEL_LAUNCHER_LAT_EN to add rsp_cycles. This
// output reports the number of WAIT cycles spent, counting the cycle in
// which done or timeout was detected as 1.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready/req_args operand request channel (arg i at [i*WIDTH +: WIDTH])
//   rsp_valid/rsp_ready          response channel
//   rsp_data/rsp_timeout         result (0 on timeout) and watchdog abort flag
//   k_r_enable/k_init            kernel load pulse and held operands
//   k_w_enable/k_result          kernel done level and result
//   rsp_cycles                   WAIT-cycle latency (KERNEL_LAUNCHER_LAT_EN only)
module kernel_launcher
    import kernel_launcher_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_ARGS  = 7,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [N_ARGS*WIDTH-1:0] req_args,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_timeout,
    output logic                    k_r_enable,
    output logic [N_ARGS*WIDTH-1:0] k_init,
    input  logic                    k_w_enable,
    input  logic [WIDTH-1:0]        k_result
`ifdef KERNEL_LAUNCHER_LAT_EN
    ,
    output logic [CNT_W-1:0]        rsp_cycles
`endif
);

    state_t                  state_reg, state_next;
    logic                    req_ready_reg, req_ready_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [WIDTH-1:0]        rsp_data_reg, rsp_data_next;
    logic                    rsp_timeout_reg, rsp_timeout_next;
    logic                    k_r_enable_reg, k_r_enable_next;
    logic [N_ARGS*WIDTH-1:0] k_init_reg, k_init_next;

    logic                    wd_clear;
    logic                    wd_enable;
    logic [CNT_W-1:0]        wd_count;
    logic                    wd_expire;

`ifdef KERNEL_LAUNCHER_LAT_EN
    logic [CNT_W-1:0]        cycles_reg, cycles_next;
`endif

    launcher_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .count  (wd_count),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            req_ready_reg   <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
            k_r_enable_reg  <= 1'b0;
            k_init_reg      <= '0;
`ifdef KERNEL_LAUNCHER_LAT_EN
            cycles_reg      <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            req_ready_reg   <= req_ready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_timeout_reg <= rsp_timeout_next;
            k_r_enable_reg  <= k_r_enable_next;
            k_init_reg      <= k_init_next;
`ifdef KERNEL_LAUNCHER_LAT_EN
            cycles_reg      <= cycles_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        req_ready_next   = req_ready_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_timeout_next = rsp_timeout_reg;
        k_r_enable_next  = 1'b0;
        k_init_next      = k_init_reg;
        wd_clear         = 1'b0;
        wd_enable        = 1'b0;
`ifdef KERNEL_LAUNCHER_LAT_EN
        cycles_next      = cycles_reg;
`endif

        case (state_reg)
            IDLE: begin
                // req_ready is high in this state, so req_valid alone is the handshake.
                if (req_valid) begin
                    k_init_next     = req_args;
                    k_r_enable_next = 1'b1;
                    req_ready_next  = 1'b0;
                    state_next      = LAUNCH;
                end
            end

            LAUNCH: begin
                // k_w_enable is deliberately not looked at here: it may still
                // carry the previous job's done level until the kernel sees the pulse.
                wd_clear   = 1'b1;
                state_next = WAIT;
            end

            WAIT: begin
                // Done is tested first so it wins over a simultaneous expiry.
                if (k_w_enable) begin
                    rsp_data_next    = k_result;
                    rsp_timeout_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
`ifdef KERNEL_LAUNCHER_LAT_EN
                    cycles_next      = wd_count + CNT_W'(1);
`endif
                end else if (wd_expire) begin
                    rsp_data_next    = '0;
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
`ifdef KERNEL_LAUNCHER_LAT_EN
                    cycles_next      = wd_count + CNT_W'(1);
`endif
                end else begin
                    wd_enable = 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    req_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifndef KERNEL_LAUNCHER_LAT_EN
    // Without the latency output the count is only consumed inside the watchdog.
    logic unused_count;
    assign unused_count = ^wd_count;
`endif

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign k_r_enable  = k_r_enable_reg;
    assign k_init      = k_init_reg;
`ifdef KERNEL_LAUNCHER_LAT_EN
    assign rsp_cycles  = cycles_reg;
`endif

endmodule

// File: tb/tb_kernel_launcher.sv
// tb_kernel_launcher: self-checking bench for kernel_launcher. A behavioural
// sum kernel model with programmable latency answers the launches. Directed
// jobs come from a vector table, followed by reset and random back-to-back
// sequences. Set KERNEL_LAUNCHER_LAT_EN to also check rsp_cycles.
module tb_kernel_launcher;

    localparam int W  = 32;
    localparam int N  = 7;
    localparam int TO = 16;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [N*W-1:0] req_args;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_timeout;
    logic           k_r_enable;
    logic [N*W-1:0] k_init;
    logic           k_w_enable;
    logic [W-1:0]   k_result;
`ifdef KERNEL_LAUNCHER_LAT_EN
    logic [CW-1:0]  rsp_cycles;
`endif

    always #5 clk = ~clk;

    kernel_launcher #(
        .WIDTH   (W),
        .N_ARGS  (N),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_args    (req_args),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .k_r_enable  (k_r_enable),
        .k_init      (k_init),
        .k_w_enable  (k_w_enable),
        .k_result    (k_result)
`ifdef KERNEL_LAUNCHER_LAT_EN
        ,
        .rsp_cycles  (rsp_cycles)
`endif
    );

    // Reference: the kernel's result is the modular sum of its operands.
    function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] a);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + a[i*W +: W];
        return s;
    endfunction

    // Kernel model: done level rises `k_lat` cycles after the load pulse
    // (done visible in the k_lat-th cycle after the pulse) and stays high
    // until the next pulse. With k_hang set it never finishes.
    logic         kw   = 1'b0;
    logic [W-1:0] kres = '0;
    logic [W-1:0] ksum = '0;
    int           kcnt = 0;
    bit           kbusy = 1'b0;
    int           k_lat = 1;
    bit           k_hang = 1'b0;

    assign k_w_enable = kw;
    assign k_result   = kres;

    always @(posedge clk) begin
        if (k_r_enable) begin
            ksum <= ref_sum(k_init);
            kcnt <= 1;
            if (!k_hang && k_lat == 1) begin
                kw    <= 1'b1;
                kres  <= ref_sum(k_init);
                kbusy <= 1'b0;
            end else begin
                kw    <= 1'b0;
                kbusy <= 1'b1;
            end
        end else if (kbusy) begin
            kcnt <= kcnt + 1;
            if (!k_hang && kcnt + 1 == k_lat) begin
                kw    <= 1'b1;
                kres  <= ksum;
                kbusy <= 1'b0;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int accepts = 0;
    int pulses = 0;

    // Every cycle with k_r_enable high counts; a stretched pulse over-counts.
    always @(negedge clk) if (k_r_enable) pulses++;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One job from accept to response handshake; starts and ends at a negedge.
    task automatic run_job(input string nm, input logic [N*W-1:0] args, input int lat,
                           input bit hang, input int bp, input bit hold,
                           input logic [W-1:0] exp_data, input bit exp_to, input int exp_wait);
        int n;
        logic [W-1:0] held;
        k_lat     = lat;
        k_hang    = hang;
        rsp_ready = (bp == 0);
        req_args  = args;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({nm, " req_ready"}, 256'(req_ready), 256'(1));
            req_valid = 1'b0;
            return;
        end
        accepts++;
        @(negedge clk);
        req_valid = hold;
        chk({nm, " pulse"}, 256'(k_r_enable), 256'(1));
        chk({nm, " k_init"}, 256'(k_init), 256'(args));
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " wait_cycles"}, 256'(n - 1), 256'(exp_wait));
        chk({nm, " rsp_data"}, 256'(rsp_data), 256'(exp_data));
        chk({nm, " rsp_timeout"}, 256'(rsp_timeout), 256'(exp_to));
`ifdef KERNEL_LAUNCHER_LAT_EN
        chk({nm, " rsp_cycles"}, 256'(rsp_cycles), 256'(exp_wait));
`endif
        held = rsp_data;
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            chk({nm, " bp_data"}, 256'(rsp_data), 256'(held));
            chk({nm, " bp_valid"}, 256'(rsp_valid), 256'(1));
            chk({nm, " bp_req_ready"}, 256'(req_ready), 256'(0));
            chk({nm, " bp_no_launch"}, 256'(k_r_enable), 256'(0));
        end
        rsp_ready = 1'b1;
        req_valid = hold;
        @(negedge clk);
        chk({nm, " idle_rsp_valid"}, 256'(rsp_valid), 256'(0));
        chk({nm, " idle_req_ready"}, 256'(req_ready), 256'(1));
        $display("job %s: data=%0h timeout=%0d", nm, rsp_data, rsp_timeout);
    endtask

    task automatic chk_reset_values(input string nm);
        chk({nm, " req_ready"}, 256'(req_ready), 256'(1));
        chk({nm, " rsp_valid"}, 256'(rsp_valid), 256'(0));
        chk({nm, " rsp_data"}, 256'(rsp_data), 256'(0));
        chk({nm, " rsp_timeout"}, 256'(rsp_timeout), 256'(0));
        chk({nm, " k_r_enable"}, 256'(k_r_enable), 256'(0));
        chk({nm, " k_init"}, 256'(k_init), 256'(0));
`ifdef KERNEL_LAUNCHER_LAT_EN
        chk({nm, " rsp_cycles"}, 256'(rsp_cycles), 256'(0));
`endif
    endtask

    typedef struct {
        string                 nm;
        logic [N-1:0][W-1:0]   args;
        int                    lat;
        bit                    hang;
        int                    bp;
        logic [W-1:0]          exp_data;
        bit                    exp_to;
        int                    exp_wait;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [N*W-1:0] ra;
        int             rl;

        // name       lat hang bp  data          to wait
        tbl[0] = '{"sum1to7",  '0,  8, 0,  0, 32'd28,         0,  8};
        tbl[1] = '{"backpr",   '0,  5, 0, 20, 32'd280,        0,  5};
        tbl[2] = '{"stale",    '0,  3, 0,  0, 32'd35,         0,  3};
        tbl[3] = '{"timeout",  '0,  1, 1,  0, 32'd0,          1, 16};
        tbl[4] = '{"lat1",     '0,  1, 0,  0, 32'd21,         0,  1};
        tbl[5] = '{"coincide", '0, 16, 0,  0, 32'd721,        0, 16};
        tbl[6] = '{"wrap",     '0,  4, 0,  0, 32'hFFFF_FFF9,  0,  4};
        for (int i = 0; i < N; i++) begin
            tbl[0].args[i] = W'(i + 1);
            tbl[1].args[i] = W'(10 * (i + 1));
            tbl[2].args[i] = W'(5);
            tbl[3].args[i] = W'(9);
            tbl[4].args[i] = W'(i);
            tbl[5].args[i] = W'(100 + i);
            tbl[6].args[i] = 32'hFFFF_FFFF;
        end

        rst       = 1'b1;
        req_valid = 1'b0;
        req_args  = '0;
        rsp_ready = 1'b1;
        #1;
        chk_reset_values("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_job(tbl[v].nm, tbl[v].args, tbl[v].lat, tbl[v].hang, tbl[v].bp, 1'b0,
                    tbl[v].exp_data, tbl[v].exp_to, tbl[v].exp_wait);
        end

        // Reset while the load pulse is high: the pulse must drop at once.
        k_lat     = 5;
        k_hang    = 1'b0;
        req_args  = {N{32'h1234_5678}};
        req_valid = 1'b1;
        @(negedge clk);
        accepts++;
        req_valid = 1'b0;
        chk("rst_launch pulse", 256'(k_r_enable), 256'(1));
        #2 rst = 1'b1;
        #1;
        chk_reset_values("rst_launch");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset three cycles into WAIT, away from any clock edge.
        req_args  = {N{32'h0BAD_F00D}};
        req_valid = 1'b1;
        @(negedge clk);
        accepts++;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_values("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_job(tbl[6].nm, tbl[6].args, tbl[6].lat, tbl[6].hang, tbl[6].bp, 1'b0,
                tbl[6].exp_data, tbl[6].exp_to, tbl[6].exp_wait);

        // Back-to-back random jobs with req_valid held high throughout.
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < N; i++) ra[i*W +: W] = $urandom;
            rl = $urandom_range(1, 12);
            run_job($sformatf("rand%0d", j), ra, rl, 1'b0, $urandom_range(0, 2), 1'b1,
                    ref_sum(ra), 1'b0, rl);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pulse_count", 256'(pulses), 256'(accepts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
